// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, shift schedule and FSM state type.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ks_state_t;

  // Entries are 1-indexed DES bit numbers of the source word (bit 1 = MSB).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_SCHED [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Rotation amount of 1-indexed round k.
  function automatic logic [1:0] shift_of(input logic [4:0] k);
    return (SHIFT_SCHED[k] == 1) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2: selects the 48-bit round subkey from the 56-bit {C,D} register pair.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign subkey[47-j] = cd[56-PC2[j]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: PC-1 on load, then one rotated {C,D} pair per accepted subkey.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_ROUNDS,
  parameter int ROUND_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           key_in,
  input  logic                  decrypt,
  input  logic                  start,
  output logic                  ready,
  output logic [47:0]           subkey,
  output logic                  subkey_valid,
  input  logic                  advance,
  output logic [ROUND_BITS-1:0] round_idx,
  output logic                  done
);

  localparam logic [ROUND_BITS-1:0] LAST_ROUND = ROUND_BITS'(NUM_ROUNDS - 1);

  ks_state_t             state;
  logic [27:0]           c_half;
  logic [27:0]           d_half;
  logic [ROUND_BITS-1:0] round_cnt;
  logic                  dir_dec;
  logic                  done_q;

  logic [55:0]           pc1_key;
  logic [1:0]            fwd_amt;
  logic [1:0]            rev_amt;

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_key[55-i] = key_in[64-PC1[i]];
  end

  // Presenting K(r+1): encrypt moves on to K(r+2); decrypt undoes the shift that produced K(16-r).
  assign fwd_amt = shift_of(5'(round_cnt) + 5'd2);
  assign rev_amt = shift_of(5'd16 - 5'(round_cnt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      c_half    <= '0;
      d_half    <= '0;
      round_cnt <= '0;
      dir_dec   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dir_dec   <= decrypt;
            round_cnt <= '0;
            state     <= ACTIVE;
            // C0/D0 equal C16/D16, so decrypt starts from the unrotated halves.
            if (decrypt) begin
              c_half <= pc1_key[55:28];
              d_half <= pc1_key[27:0];
            end else begin
              c_half <= rotl28(pc1_key[55:28], 2'd1);
              d_half <= rotl28(pc1_key[27:0], 2'd1);
            end
          end
        end
        ACTIVE: begin
          if (advance) begin
            if (round_cnt == LAST_ROUND) begin
              state     <= IDLE;
              round_cnt <= '0;
              done_q    <= 1'b1;
            end else begin
              round_cnt <= round_cnt + 1'b1;
              if (dir_dec) begin
                c_half <= rotr28(c_half, rev_amt);
                d_half <= rotr28(d_half, rev_amt);
              end else begin
                c_half <= rotl28(c_half, fwd_amt);
                d_half <= rotl28(d_half, fwd_amt);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_half, d_half}),
    .subkey (subkey)
  );

  assign ready        = (state == IDLE);
  assign subkey_valid = (state == ACTIVE);
  assign round_idx    = round_cnt;
  assign done         = done_q;

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES subkey generator for the 3DES datapath. Accepts a 64-bit key, applies PC-1, and produces the 16 48-bit round subkeys one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1). It sits directly upstream of the round engine and its round counter: the consumer pulls one subkey per round with `advance`, and `done` marks the end of the 16-round sequence.

## Interface
- `NUM_ROUNDS`, 16, rounds per key sequence; only 16 is legal.
- `ROUND_BITS`, 4, width of `round_idx`.

Ports (all widths fixed):
- `clk` input 1, system clock, rising edge.
- `rst` input 1, reset. One clock; reset is asynchronous and active-high.
- `key_in` input 64, DES key; bit 63 = DES bit 1; parity bits ignored.
- `decrypt` input 1, direction, sampled with `start`; 1 = reverse order.
- `start` input 1, load request; accepted only when `ready`=1.
- `ready` output 1, high in IDLE.
- `subkey` output 48, current subkey, PC-2(C,D); bit 47 = DES bit 1.
- `subkey_valid` output 1, high in ACTIVE.
- `advance` input 1, consumer accepts the current subkey; effective only when `subkey_valid`=1.
- `round_idx` output 4, sequence position 0..15 of the presented subkey.
- `done` output 1, one-cycle pulse after the 16th subkey is accepted.

## Operation
- Registers: C[27:0], D[27:0], round counter r[3:0], direction flag, state, done.
- Shift schedule, 1-indexed: rounds 1, 2, 9 and 16 shift by 1; all other rounds shift by 2.
- IDLE (reset state): `ready`=1, `subkey_valid`=0. On `start`:
  - {C,D} = PC-1(`key_in`); r=0; latch `decrypt`; go to ACTIVE.
  - Encrypt: C and D are loaded already rotated left by 1 (C1, D1), so K1 is presented first.
  - Decrypt: C0 and D0 are loaded unrotated (equal to C16, D16), so K16 is presented first.
- ACTIVE: `subkey` = PC-2(C,D); `round_idx` = r. On `advance`:
  - r<15, encrypt: rotate C and D left by shift[r+2]; r++.
  - r<15, decrypt: rotate C and D right by shift[16-r]; r++.
  - r==15: go to IDLE and assert `done` for the next cycle. C and D hold their value; r is cleared.
- `advance` without `subkey_valid` is ignored. `start` while ACTIVE is ignored, with no restart.
- `advance` held high continuously is legal and produces 16 subkeys on 16 consecutive cycles.
- `decrypt` and `key_in` changes after acceptance have no effect until the next `start`.
- Rotations are modulo 28 within each half. C and D never mix.

## Timing
- Reset values:
  - `ready`=1.
  - `subkey_valid`=0, `done`=0.
  - `round_idx`=0.
  - `subkey`=PC-2(0)=0.
  - C=0, D=0, state=IDLE.
- `rst` mid-sequence immediately aborts: outputs take their reset values asynchronously, and no `done` is produced.
- Latency:
  - `start` at edge N gives `subkey_valid`=1 with the first subkey from edge N+1.
  - Each `advance` edge presents the next subkey in the same cycle after the edge, with no bubble.
- `done` rises at the edge that accepts the 16th subkey. In that same cycle `ready`=1, so `start` may be accepted: back-to-back keys need a minimum of 17 cycles per key.
- `subkey` is combinational from registers only. There is no input-to-output combinational path.

## Structure
- `des_pkg` holds:
  - PC-1 table (56 entries) and PC-2 table (48 entries) as localparam arrays.
  - `SHIFT_SCHED[1:16]`.
  - `typedef enum logic {IDLE, ACTIVE} ks_state_t`.
  - `DES_ROUNDS`=16.
- One combinational sub-module, `des_pc2`: 56-bit {C,D} in, 48-bit subkey out. It is reused by a future single-cycle key path.
- PC-1 is applied inline at load.

## Test plan
- Reset value check: assert `rst` asynchronously mid-cycle -> `ready`=1, `subkey_valid`=0, `done`=0, `round_idx`=0 immediately.
- Encrypt sequence with held `advance`: `key_in`=0x133457799BBCDFF1, `decrypt`=0, `start`, then `advance` held high ->
  - first `subkey`=0x1B02EFFC7072 with `round_idx`=0;
  - 16th `subkey`=0xCB3D8B0E17F5 with `round_idx`=15;
  - `done` pulses once;
  - `ready` returns on the cycle after the 16th accept.
- Decrypt sequence: same key, `decrypt`=1 -> first `subkey`=0xCB3D8B0E17F5, last `subkey`=0x1B02EFFC7072; the full sequence equals the encrypt sequence reversed (checked against a reference model).
- Irregular advance: random gaps in `advance`, plus `advance` pulses while IDLE -> subkeys unchanged while stalled; no extra rounds; exactly 16 accepts before `done`.
- Ignored restart: `start` with a different key at `round_idx`=7 -> ignored, and the sequence completes with the original key. Then `rst` at `round_idx`=5 -> no `done`; a subsequent `start` produces K1 correctly.
- Back-to-back keys: `start` asserted in the `done` cycle with key 0x0000000000000000 -> accepted; all 16 subkeys = 0x000000000000.
